// File: rtl/cfg_reg_pkg.sv
// Shared constants and helpers for the configuration register bank.
// Reset images are packed register-0-first, WIDTH bits per register.
package cfg_reg_pkg;

  localparam int RD_LAT_MAX = 4;
  localparam int WIDTH_MAX  = 64;
  localparam int INIT_MAX   = 4096;

  localparam logic [INIT_MAX-1:0] DEF_RST_INIT =
    INIT_MAX'(32'h081D_0000);

  function automatic logic [WIDTH_MAX-1:0] init_slice(
    input logic [INIT_MAX-1:0] init,
    input int                  i,
    input int                  w
  );
    logic [INIT_MAX-1:0] m;
    m = (INIT_MAX'(1) << w) - INIT_MAX'(1);
    return WIDTH_MAX'((init >> (i * w)) & m);
  endfunction

endpackage

// File: rtl/cfg_reg_bank_if.sv
// Command-side bus of the configuration register bank.
// The controller is the master; the bank is the slave.
interface cfg_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
);

  logic             WrEn;
  logic             RdEn;
  logic [ADDR-1:0]  Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] WrMask;
  logic [WIDTH-1:0] RdData;
  logic             RdData_VLD;
  logic             Err;

  modport master (
    output WrEn, RdEn, Address, WrData, WrMask,
    input  RdData, RdData_VLD, Err
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData, WrMask,
    output RdData, RdData_VLD, Err
  );

endinterface

// File: rtl/cfg_rd_pipe.sv
// LAT-stage {valid, data} delay line with asynchronous clear.
// Data stages only load on valid, so the output holds the last read.
module cfg_rd_pipe #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  logic [LAT-1:0]   vin;
  logic [WIDTH-1:0] din   [LAT];
  logic [LAT-1:0]   vld_d;
  logic [LAT-1:0]   vld_q;
  logic [WIDTH-1:0] dat_d [LAT];
  logic [WIDTH-1:0] dat_q [LAT];

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vin[k] = in_vld;
      assign din[k] = in_dat;
    end else begin : g_body
      assign vin[k] = vld_q[k-1];
      assign din[k] = dat_q[k-1];
    end
  end

  always_comb begin
    vld_d = vin;
    for (int k = 0; k < LAT; k++) begin
      dat_d[k] = vin[k] ? din[k] : dat_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/cfg_reg_bank.sv
// Configuration register bank: masked writes, pipelined reads,
// error pulses and change strobes for the exported registers.
module cfg_reg_bank
  import cfg_reg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR    = 4,
  parameter int NUM_EXP = 4,
  parameter int RD_LAT  = 1,
  parameter logic [DEPTH*WIDTH-1:0] RST_INIT =
    (DEPTH*WIDTH)'(DEF_RST_INIT)
) (
  input  logic                     CLK,
  input  logic                     RST,
  cfg_reg_bank_if.slave            bus,
  output logic [NUM_EXP*WIDTH-1:0] REG_OUT,
  output logic [NUM_EXP-1:0]       Upd
);

  logic [WIDTH-1:0]   init_v [DEPTH];
  logic [WIDTH-1:0]   reg_d  [DEPTH];
  logic [WIDTH-1:0]   reg_q  [DEPTH];
  logic               in_range;
  logic               coll;
  logic               wr_ok;
  logic               rd_req;
  logic [WIDTH-1:0]   rd_sample;
  logic               err_d;
  logic               err_q;
  logic [NUM_EXP-1:0] upd_d;
  logic [NUM_EXP-1:0] upd_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_init
    assign init_v[i] =
      WIDTH'(init_slice(INIT_MAX'(RST_INIT), i, WIDTH));
  end

  always_comb begin
    in_range  = {1'b0, bus.Address} < (ADDR+1)'(DEPTH);
    coll      = bus.WrEn & bus.RdEn;
    wr_ok     = bus.WrEn & ~bus.RdEn & in_range;
    rd_req    = bus.RdEn & ~bus.WrEn;
    err_d     = coll | ((bus.WrEn | bus.RdEn) & ~in_range);
    rd_sample = '0;
    if (in_range) begin
      rd_sample = reg_q[bus.Address];
    end
  end

  // A strobe fires only when the masked merge actually flips a bit.
  always_comb begin
    reg_d = reg_q;
    upd_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && bus.Address == ADDR'(i)) begin
        reg_d[i] = (reg_q[i] & ~bus.WrMask) |
                   (bus.WrData & bus.WrMask);
      end
    end
    for (int k = 0; k < NUM_EXP; k++) begin
      upd_d[k] = reg_d[k] != reg_q[k];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= init_v[i];
      end
      err_q <= 1'b0;
      upd_q <= '0;
    end else begin
      reg_q <= reg_d;
      err_q <= err_d;
      upd_q <= upd_d;
    end
  end

  cfg_rd_pipe #(
    .WIDTH (WIDTH),
    .LAT   (RD_LAT)
  ) u_rd_pipe (
    .clk     (CLK),
    .rst     (RST),
    .in_vld  (rd_req),
    .in_dat  (rd_sample),
    .out_vld (bus.RdData_VLD),
    .out_dat (bus.RdData)
  );

  assign bus.Err = err_q;
  assign Upd     = upd_q;

  for (genvar k = 0; k < NUM_EXP; k++) begin : g_exp
    assign REG_OUT[k*WIDTH +: WIDTH] = reg_q[k];
  end

endmodule
